// File: rtl/amber_wb_pkg.sv
// rtl/amber_wb_pkg.sv - shared types, widths and lane helper for the Wishbone slave responder
//
// Purpose: state encoding of the responder FSM, Wishbone bus widths and the
//          byte-select to bit-mask helper used by the memory write merge.
// Ports:   none (package).

package amber_wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_t;

  // Expand each select bit to cover its 8-bit data lane.
  function automatic logic [WB_DAT_W-1:0] sel_to_mask(input logic [WB_SEL_W-1:0] sel);
    logic [WB_DAT_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < WB_SEL_W; i++) begin
      mask[8*i +: 8] = {8{sel[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_resp_mem.sv
// rtl/wb_resp_mem.sv - word memory with per-lane bus write, backdoor word write and async read
//
// Purpose: backing store for the responder. Bus writes touch only selected
//          lanes; the backdoor writes a whole word. When both hit the same word
//          in one cycle the bus lanes win and the other lanes take backdoor data.
// Ports:   clk                  - clock, rising edge
//          bus_we/bus_idx       - bus write strobe and word index
//          bus_sel/bus_dat      - bus byte selects and write data
//          bd_we/bd_idx/bd_dat  - backdoor full-word write
//          rd_idx/rd_dat        - asynchronous read port

module wb_resp_mem
  import amber_wb_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic                clk,
  input  logic                bus_we,
  input  logic [AW-1:0]       bus_idx,
  input  logic [WB_SEL_W-1:0] bus_sel,
  input  logic [WB_DAT_W-1:0] bus_dat,
  input  logic                bd_we,
  input  logic [AW-1:0]       bd_idx,
  input  logic [WB_DAT_W-1:0] bd_dat,
  input  logic [AW-1:0]       rd_idx,
  output logic [WB_DAT_W-1:0] rd_dat
);

  localparam int DEPTH = 1 << AW;

  logic [WB_DAT_W-1:0] mem [DEPTH];
  logic [WB_DAT_W-1:0] mask;
  logic [WB_DAT_W-1:0] base;
  logic [WB_DAT_W-1:0] merged;

  // Unselected lanes keep the old word, unless the backdoor is writing the
  // same word this cycle, in which case they take the backdoor data.
  always_comb begin
    mask   = sel_to_mask(bus_sel);
    base   = (bd_we && (bd_idx == bus_idx)) ? bd_dat : mem[bus_idx];
    merged = (bus_dat & mask) | (base & ~mask);
  end

  // The bus write is issued last so it overrides the backdoor on a collision;
  // the merged value already carries the backdoor bytes for the other lanes.
  always_ff @(posedge clk) begin
    if (bd_we) begin
      mem[bd_idx] <= bd_dat;
    end
    if (bus_we) begin
      mem[bus_idx] <= merged;
    end
  end

  assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/amber_wb_slave_responder.sv
// rtl/amber_wb_slave_responder.sv - Wishbone B3 classic slave with wait states, range errors and backdoor preload
//
// Purpose: answers Amber core bus cycles from a word memory with registered
//          ack/err pulses, a programmable number of wait states per transfer,
//          error termination outside the mapped window and a transfer counter.
// Ports:   clk, rst_n                    - clock and async active-low reset
//          i_wb_adr/sel/we/dat/cyc/stb   - Wishbone master request
//          o_wb_dat/o_wb_ack/o_wb_err    - Wishbone response
//          i_wait_cycles                 - wait states, sampled at acceptance
//          i_bd_we/i_bd_adr/i_bd_dat     - backdoor word write
//          o_busy                        - transfer in progress
//          o_txn_count                   - terminated transfers (wrapping)

module amber_wb_slave_responder
  import amber_wb_pkg::*;
#(
  parameter int                  MEM_WORDS = 1024,
  parameter logic [WB_ADR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int                  CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WB_ADR_W-1:0]          i_wb_adr,
  input  logic [WB_SEL_W-1:0]          i_wb_sel,
  input  logic                         i_wb_we,
  input  logic [WB_DAT_W-1:0]          i_wb_dat,
  input  logic                         i_wb_cyc,
  input  logic                         i_wb_stb,
  output logic [WB_DAT_W-1:0]          o_wb_dat,
  output logic                         o_wb_ack,
  output logic                         o_wb_err,
  input  logic [3:0]                   i_wait_cycles,
  input  logic                         i_bd_we,
  input  logic [$clog2(MEM_WORDS)-1:0] i_bd_adr,
  input  logic [WB_DAT_W-1:0]          i_bd_dat,
  output logic                         o_busy,
  output logic [CNT_W-1:0]             o_txn_count
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [WB_ADR_W:0] SPAN = (WB_ADR_W + 1)'(MEM_WORDS) << 2;

  wb_state_t             state;
  logic [3:0]            cnt;
  logic [WB_ADR_W-1:0]   lat_adr;
  logic [WB_SEL_W-1:0]   lat_sel;
  logic                  lat_we;
  logic [WB_DAT_W-1:0]   lat_dat;

  logic                  req;
  logic                  fire;
  logic [WB_ADR_W-1:0]   src_adr;
  logic [WB_SEL_W-1:0]   src_sel;
  logic                  src_we;
  logic [WB_DAT_W-1:0]   src_dat;
  logic [WB_ADR_W:0]     offset;
  logic                  hit;
  logic [AW-1:0]         idx;
  logic [WB_DAT_W-1:0]   rd_dat;

  assign req = i_wb_cyc & i_wb_stb;

  // A zero-wait transfer terminates on the very edge that accepts it, so the
  // response path reads the live bus in IDLE and the latched request otherwise.
  always_comb begin
    if (state == IDLE) begin
      src_adr = i_wb_adr;
      src_sel = i_wb_sel;
      src_we  = i_wb_we;
      src_dat = i_wb_dat;
    end else begin
      src_adr = lat_adr;
      src_sel = lat_sel;
      src_we  = lat_we;
      src_dat = lat_dat;
    end
  end

  // Offset below the base wraps past 2^32, so one unsigned compare covers both bounds.
  assign offset = {1'b0, src_adr} - {1'b0, BASE_ADDR};
  assign hit    = (offset < SPAN);
  assign idx    = offset[AW+1:2];

  // fire marks the edge that registers ack/err and commits a bus write.
  always_comb begin
    fire = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE:    fire = req && (i_wait_cycles == 4'd0);
        WAIT:    fire = req && (cnt == 4'd1);
        default: fire = 1'b0;
      endcase
    end
  end

  wb_resp_mem #(
    .AW (AW)
  ) u_mem (
    .clk     (clk),
    .bus_we  (fire & hit & src_we),
    .bus_idx (idx),
    .bus_sel (src_sel),
    .bus_dat (src_dat),
    .bd_we   (i_bd_we),
    .bd_idx  (i_bd_adr),
    .bd_dat  (i_bd_dat),
    .rd_idx  (idx),
    .rd_dat  (rd_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      lat_adr     <= '0;
      lat_sel     <= '0;
      lat_we      <= 1'b0;
      lat_dat     <= '0;
      o_wb_ack    <= 1'b0;
      o_wb_err    <= 1'b0;
      o_wb_dat    <= '0;
      o_busy      <= 1'b0;
      o_txn_count <= '0;
    end else begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      o_wb_dat <= '0;

      if (fire) begin
        o_txn_count <= o_txn_count + CNT_W'(1);
        if (hit) begin
          o_wb_ack <= 1'b1;
          if (!src_we) begin
            o_wb_dat <= rd_dat;
          end
        end else begin
          o_wb_err <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (req) begin
            lat_adr <= i_wb_adr;
            lat_sel <= i_wb_sel;
            lat_we  <= i_wb_we;
            lat_dat <= i_wb_dat;
            o_busy  <= 1'b1;
            if (i_wait_cycles != 4'd0) begin
              cnt   <= i_wait_cycles;
              state <= WAIT;
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            // Master gave up: drop the transfer without any termination.
            cnt    <= 4'd0;
            o_busy <= 1'b0;
            state  <= IDLE;
          end else if (cnt == 4'd1) begin
            cnt   <= 4'd0;
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/amber_wb_slave_responder.md
Name: amber_wb_slave_responder

Overview:
Wishbone B3 classic slave that answers the Amber core's bus master port (instruction fetch and data access) from a byte-lane-writable word memory. It sits on the bench/SoC side opposite the core. It provides registered ack/err, programmable wait states, address-range error reporting and a backdoor preload port so sequences can place instructions and data without bus cycles.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in the backing memory (power of 2)
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*MEM_WORDS
CNT_W, 16, width of the transaction counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_wb_adr  input  32  byte address from master
i_wb_sel  input  4  byte-lane selects; bit n covers data[8n+7:8n]
i_wb_we  input  1  1 = write, 0 = read
i_wb_dat  input  32  write data from master
i_wb_cyc  input  1  bus cycle active
i_wb_stb  input  1  strobe / request valid
o_wb_dat  output  32  read data, valid only while o_wb_ack=1
o_wb_ack  output  1  normal termination, one-cycle pulse
o_wb_err  output  1  error termination, one-cycle pulse
i_wait_cycles  input  4  wait states inserted before termination, sampled at request acceptance
i_bd_we  input  1  backdoor word write strobe
i_bd_adr  input  log2(MEM_WORDS)  backdoor word index
i_bd_dat  input  32  backdoor write data
o_busy  output  1  1 whenever FSM is not IDLE
o_txn_count  output  CNT_W  number of terminated transfers (ack or err)

Behaviour:
- One clock domain, clk; reset is asynchronous, active-low (rst_n). Reset forces state IDLE, wait counter 0, and o_wb_ack, o_wb_err, o_busy, o_wb_dat, o_txn_count all to 0. Memory contents are not cleared. Reset asserted mid-transfer aborts it with no write and no termination pulse.
- Request = i_wb_cyc & i_wb_stb sampled in IDLE. On acceptance, latch adr, sel, we, dat and i_wait_cycles. Hit = BASE_ADDR <= adr < BASE_ADDR+4*MEM_WORDS. Word index = adr[log2(MEM_WORDS)+1:2]. adr[1:0] is ignored.
- States:
  - IDLE: on request, go to WAIT if latched wait > 0 (counter = wait), else go to RESP.
  - WAIT: counter decrements each cycle. Go to RESP when the counter reaches 1. If cyc or stb drops, go to IDLE (abort, no write, no pulse, counter not incremented).
  - RESP: outputs registered from this state, so the pulse is high for exactly one cycle. Always return to IDLE next.
- Latency: with wait=0, request seen at edge N gives ack/err high in cycle N+1. With wait=W, ack/err is high in cycle N+1+W. Maximum throughput is one transfer per 2 cycles, because IDLE re-samples stb the cycle after RESP. Continuous stb from Amber is legal.
- RESP hit, read: o_wb_ack=1; o_wb_dat = mem[index], all 4 bytes regardless of sel.
- RESP hit, write: o_wb_ack=1; only selected lanes are written, on the RESP edge. sel=4'b0000 gives ack with no change. o_wb_dat=0.
- RESP miss: o_wb_err=1, o_wb_ack=0, no memory change, o_wb_dat=0.
- o_wb_ack and o_wb_err are never high together. o_wb_dat is 0 whenever o_wb_ack=0.
- o_txn_count increments by 1 on every ack or err pulse and wraps from all-ones to 0.
- Backdoor: i_bd_we writes the full word mem[i_bd_adr] at the clock edge in any state. If it hits the same word as a bus write committing in the same cycle, bus-selected lanes win and the remaining lanes take i_bd_dat.
- A bus read in RESP sees memory as it was before that edge's writes (read-before-write).

Decomposition:
- Package amber_wb_pkg:
  - state enum {IDLE, WAIT, RESP}
  - WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4
  - byte-lane mask function sel-to-32-bit-mask
- Sub-module wb_resp_mem: single-clock word memory with per-lane bus write, full-word backdoor write, merge rule above, and asynchronous read port.
- The FSM, counter and termination logic stay in the top.

Test Plan:
- Backdoor mem[3]=32'hE3A01005; read adr 32'h0C, sel 4'hF, wait 0 -> ack=1 exactly one cycle after request, o_wb_dat=32'hE3A01005, o_txn_count=1.
- mem[5]=32'h11223344; write adr 32'h14, sel 4'b0101, dat 32'hAABBCCDD, then read back -> ack on write with no err, readback 32'h11BB33DD.
- wait=3, read adr 32'h0 -> ack in 4th cycle after acceptance, o_busy high 4 cycles; drop stb in 2nd wait cycle on a repeat -> no ack, no err, count unchanged.
- MEM_WORDS=1024, adr 32'h0000_1000 write -> o_wb_err=1 for one cycle, ack=0, memory unchanged, count increments.
- stb/cyc held high for 4 consecutive reads at 0x0,0x4,0x8,0xC -> 4 acks on alternating cycles, data in address order.
- Assert rst_n low during WAIT of a write to 0x8 -> no ack or err, mem[2] unchanged, all outputs 0; after release, next read of 0x8 acks normally.
